universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_frame_counter.sv | 37 +++
 rtl/universal_shift_reg.sv | 84 ++++++++
 tb/tb_universal_shift_reg.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'd0,
      MODE_SHR  = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_ROR  = 3'd3,
      MODE_ROL  = 3'd4,
      MODE_LOAD = 3'd5,
      MODE_ASR  = 3'd6,
      MODE_RSVD = 3'd7
   } mode_e;

endpackage

// File: rtl/usr_frame_counter.sv
// Counts shifts modulo BITS and emits a registered one-cycle done pulse on wrap.
module usr_frame_counter #(
   parameter int BITS = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    step,
   input  logic                    clear,
   output logic [$clog2(BITS)-1:0] cnt,
   output logic                    done
);

   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clear) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (step) begin
         if (cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
         end else begin
            cnt  <= cnt + 1'b1;
            done <= 1'b0;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: shift/rotate/load data path plus frame counting.
// Define USR_ARITH_SHIFT_EN to enable mode 6 (arithmetic shift right).
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int BITS = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    en,
   input  logic [MODE_W-1:0]       mode,
   input  logic                    sin_r,
   input  logic                    sin_l,
   input  logic [BITS-1:0]         pin,
   output logic [BITS-1:0]         pout,
   output logic                    so_r,
   output logic                    so_l,
   output logic [$clog2(BITS)-1:0] cnt,
   output logic                    done
);

   logic [BITS-1:0] data_q;
   logic [BITS-1:0] data_d;
   logic            is_shift;
   logic            is_load;

   always_comb begin
      // NOTE: defaults first so every path assigns every signal; no latch is inferred.
      data_d   = data_q;
      is_shift = 1'b0;
      is_load  = 1'b0;
      case (mode)
         MODE_SHR: begin
            data_d   = {sin_r, data_q[BITS-1:1]};
            is_shift = 1'b1;
         end
         MODE_SHL: begin
            data_d   = {data_q[BITS-2:0], sin_l};
            is_shift = 1'b1;
         end
         MODE_ROR: begin
            data_d   = {data_q[0], data_q[BITS-1:1]};
            is_shift = 1'b1;
         end
         MODE_ROL: begin
            data_d   = {data_q[BITS-2:0], data_q[BITS-1]};
            is_shift = 1'b1;
         end
         MODE_LOAD: begin
            data_d  = pin;
            is_load = 1'b1;
         end
`ifdef USR_ARITH_SHIFT_EN
         MODE_ASR: begin
            data_d   = {data_q[BITS-1], data_q[BITS-1:1]};
            is_shift = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)     data_q <= '0;
      else if (en) data_q <= data_d;
   end

   // Gating with en here keeps the counter frozen and done low while disabled.
   usr_frame_counter #(
      .BITS (BITS)
   ) u_frame_counter (
      .CLK   (CLK),
      .RST   (RST),
      .step  (en & is_shift),
      .clear (en & is_load),
      .cnt   (cnt),
      .done  (done)
   );

   assign pout = data_q;
   assign so_r = data_q[0];
   assign so_l = data_q[BITS-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (BITS=4) using a model-fed scoreboard.
module tb_universal_shift_reg;

   localparam int BITS = 4;
   localparam int CW   = $clog2(BITS);
   localparam int VW   = BITS + CW + 3;

   localparam logic [2:0] M_HOLD = 3'd0, M_SHR = 3'd1, M_SHL = 3'd2, M_ROR = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4, M_LOAD = 3'd5, M_ASR = 3'd6, M_RSVD = 3'd7;

   logic            CLK = 1'b0;
   logic            RST;
   logic            en;
   logic [2:0]      mode;
   logic            sin_r, sin_l;
   logic [BITS-1:0] pin, pout;
   logic            so_r, so_l;
   logic [CW-1:0]   cnt;
   logic            done;

   typedef struct {
      logic [BITS-1:0] pout;
      logic [CW-1:0]   cnt;
      logic            done;
   } exp_t;

   exp_t            sb[$];
   logic [BITS-1:0] m_pout;
   int              m_cnt;
   logic            m_done;
   int              total = 0;
   int              bad   = 0;

   universal_shift_reg #(.BITS(BITS)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .en    (en),
      .mode  (mode),
      .sin_r (sin_r),
      .sin_l (sin_l),
      .pin   (pin),
      .pout  (pout),
      .so_r  (so_r),
      .so_l  (so_l),
      .cnt   (cnt),
      .done  (done)
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      m_pout = '0;
      m_cnt  = 0;
      m_done = 1'b0;
   endtask

   task automatic model_shift(input logic [BITS-1:0] nxt);
      m_pout = nxt;
      m_cnt  = m_cnt + 1;
      m_done = (m_cnt == BITS);
      if (m_cnt == BITS) m_cnt = 0;
   endtask

   task automatic model_step(input logic e, input logic [2:0] md, input logic sr,
                             input logic sl, input logic [BITS-1:0] p);
      m_done = 1'b0;
      if (e) begin
         case (md)
            M_SHR:  model_shift({sr, m_pout[BITS-1:1]});
            M_SHL:  model_shift({m_pout[BITS-2:0], sl});
            M_ROR:  model_shift({m_pout[0], m_pout[BITS-1:1]});
            M_ROL:  model_shift({m_pout[BITS-2:0], m_pout[BITS-1]});
            M_LOAD: begin m_pout = p; m_cnt = 0; end
`ifdef USR_ARITH_SHIFT_EN
            M_ASR:  model_shift({m_pout[BITS-1], m_pout[BITS-1:1]});
`endif
            default: ;
         endcase
      end
   endtask

   // Drive one cycle at the falling edge, record the expectation, sample after the rising edge.
   task automatic cycle(input logic e, input logic [2:0] md, input logic sr,
                        input logic sl, input logic [BITS-1:0] p);
      @(negedge CLK);
      en = e; mode = md; sin_r = sr; sin_l = sl; pin = p;
      model_step(e, md, sr, sl, p);
      sb.push_back('{pout: m_pout, cnt: CW'(m_cnt), done: m_done});
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      en = 1'b0; mode = M_HOLD;
      RST = 1'b1;
      #1;
      RST = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      exp_t e;
      RST = 1'b1; en = 1'b1; mode = M_SHL; sin_r = 1'b1; sin_l = 1'b1; pin = '1;
      model_reset();
      #1;
      total++;
      if ({pout, cnt, done} !== {BITS'(0), CW'(0), 1'b0}) begin
         bad++;
         $display("FAIL reset_async: got pout=%b cnt=%0d done=%b, want 0/0/0", pout, cnt, done);
      end
      repeat (2) @(posedge CLK);
      #1;
      total++;
      if ({pout, so_r, so_l, cnt, done} !== '0) begin
         bad++;
         $display("FAIL reset_held: got pout=%b so_r=%b so_l=%b cnt=%0d done=%b, want all 0",
                  pout, so_r, so_l, cnt, done);
      end
      @(negedge CLK);
      RST = 1'b0; en = 1'b0;
      cycle(1'b0, M_HOLD, 1'b0, 1'b0, '0);
      e = sb.pop_front();
      total++;
      if ({pout, cnt, done} !== {e.pout, e.cnt, e.done}) begin
         bad++;
         $display("FAIL reset_release: got %b/%0d/%b want %b/%0d/%b", pout, cnt, done, e.pout, e.cnt, e.done);
      end
   endtask

   task automatic test_shr_frame();
      exp_t e;
      logic [VW-1:0] got, want;
      logic [3:0] so_seq = 4'b1011;
      cycle(1'b1, M_LOAD, 1'b0, 1'b0, 4'b1011);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         total++;
         if (so_r !== so_seq[i]) begin
            bad++;
            $display("FAIL shr_so_r[%0d]: got %b want %b", i, so_r, so_seq[i]);
         end
         cycle(1'b1, M_SHR, 1'b0, 1'b0, '0);
         e = sb.pop_front();
         got  = {pout, so_r, so_l, cnt, done};
         want = {e.pout, e.pout[0], e.pout[BITS-1], e.cnt, e.done};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL shr_step%0d: got {pout,so_r,so_l,cnt,done}=%b want %b", i, got, want);
         end
      end
      total++;
      if (pout !== 4'b0000 || done !== 1'b1) begin
         bad++;
         $display("FAIL shr_end: got pout=%b done=%b want 0000/1", pout, done);
      end
      cycle(1'b1, M_HOLD, 1'b0, 1'b0, '0);
      void'(sb.pop_front());
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL shr_done_clear: got done=%b want 0", done);
      end
   endtask

   task automatic test_rotate();
      exp_t e;
      logic [2:0] md [4] = '{M_LOAD, M_ROL, M_ROR, M_ROR};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, md[i], 1'b1, 1'b1, 4'b1000);
         e = sb.pop_front();
         total++;
         if ({pout, cnt, done} !== {e.pout, e.cnt, e.done}) begin
            bad++;
            $display("FAIL rotate_step%0d: got %b/%0d/%b want %b/%0d/%b", i, pout, cnt, done, e.pout, e.cnt, e.done);
         end
         if (i == 1) begin
            total++;
            if (pout !== 4'b0001) begin
               bad++;
               $display("FAIL rol_result: got %b want 0001", pout);
            end
         end
      end
      total++;
      if (pout !== 4'b0100 || cnt !== CW'(3)) begin
         bad++;
         $display("FAIL ror_result: got pout=%b cnt=%0d want 0100/3", pout, cnt);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [7:0] done_seen;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, M_SHL, 1'b0, 1'b1, '0);
         e = sb.pop_front();
         done_seen[i] = done;
         total++;
         if ({pout, cnt, done} !== {e.pout, e.cnt, e.done}) begin
            bad++;
            $display("FAIL b2b_step%0d: got %b/%0d/%b want %b/%0d/%b", i, pout, cnt, done, e.pout, e.cnt, e.done);
         end
         if (i == 3) begin
            total++;
            if (pout !== 4'b1111) begin
               bad++;
               $display("FAIL b2b_fill: got %b want 1111", pout);
            end
         end
      end
      total++;
      if (done_seen !== 8'b1000_1000) begin
         bad++;
         $display("FAIL b2b_done_pattern: got %b want 10001000", done_seen);
      end
   endtask

   task automatic test_enable();
      exp_t e;
      logic [6:0] done_seen;
      logic       ens [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      cycle(1'b1, M_LOAD, 1'b0, 1'b0, 4'b0110);
      void'(sb.pop_front());
      for (int i = 0; i < 7; i++) begin
         cycle(ens[i], M_SHR, 1'b1, 1'b0, '0);
         e = sb.pop_front();
         done_seen[i] = done;
         total++;
         if ({pout, cnt, done} !== {e.pout, e.cnt, e.done}) begin
            bad++;
            $display("FAIL enable_step%0d: got %b/%0d/%b want %b/%0d/%b", i, pout, cnt, done, e.pout, e.cnt, e.done);
         end
         if (i == 4) begin
            total++;
            if (pout !== 4'b1101 || cnt !== CW'(2)) begin
               bad++;
               $display("FAIL enable_frozen: got pout=%b cnt=%0d want 1101/2", pout, cnt);
            end
         end
      end
      total++;
      if (done_seen !== 7'b100_0000 || pout !== 4'b1111) begin
         bad++;
         $display("FAIL enable_done: got done_seen=%b pout=%b want 1000000/1111", done_seen, pout);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      logic [3:0] done_seen;
      cycle(1'b1, M_LOAD, 1'b0, 1'b0, 4'b1111);
      cycle(1'b1, M_SHR, 1'b0, 1'b0, '0);
      cycle(1'b1, M_SHR, 1'b0, 1'b0, '0);
      repeat (3) void'(sb.pop_front());
      total++;
      if (pout !== 4'b0011 || cnt !== CW'(2)) begin
         bad++;
         $display("FAIL areset_pre: got pout=%b cnt=%0d want 0011/2", pout, cnt);
      end
      #2;
      RST = 1'b1;
      #1;
      total++;
      if (pout !== 4'b0000 || cnt !== CW'(0) || done !== 1'b0) begin
         bad++;
         $display("FAIL areset_immediate: got pout=%b cnt=%0d done=%b want 0000/0/0", pout, cnt, done);
      end
      RST = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, M_SHL, 1'b0, 1'b1, '0);
         e = sb.pop_front();
         done_seen[i] = done;
         total++;
         if ({pout, cnt, done} !== {e.pout, e.cnt, e.done}) begin
            bad++;
            $display("FAIL areset_step%0d: got %b/%0d/%b want %b/%0d/%b", i, pout, cnt, done, e.pout, e.cnt, e.done);
         end
         if (i == 0) begin
            total++;
            if (cnt !== CW'(1)) begin
               bad++;
               $display("FAIL areset_first_count: got cnt=%0d want 1", cnt);
            end
         end
      end
      total++;
      if (done_seen !== 4'b1000) begin
         bad++;
         $display("FAIL areset_done: got %b want 1000", done_seen);
      end
   endtask

   task automatic test_asr_and_reserved();
      exp_t e;
      logic [BITS-1:0] asr_want;
      logic [CW-1:0]   asr_cnt;
`ifdef USR_ARITH_SHIFT_EN
      asr_want = 4'b1101;
      asr_cnt  = CW'(1);
`else
      asr_want = 4'b1010;
      asr_cnt  = CW'(0);
`endif
      cycle(1'b1, M_LOAD, 1'b0, 1'b0, 4'b1010);
      cycle(1'b1, M_ASR, 1'b0, 1'b0, '0);
      repeat (2) void'(sb.pop_front());
      total++;
      if (pout !== asr_want || cnt !== asr_cnt || done !== 1'b0) begin
         bad++;
         $display("FAIL mode6: got pout=%b cnt=%0d done=%b want %b/%0d/0", pout, cnt, done, asr_want, asr_cnt);
      end
      cycle(1'b1, M_RSVD, 1'b1, 1'b1, 4'b0101);
      cycle(1'b1, M_HOLD, 1'b1, 1'b1, 4'b0101);
      repeat (2) begin
         e = sb.pop_front();
         total++;
         if ({pout, cnt, done} !== {e.pout, e.cnt, e.done}) begin
            bad++;
            $display("FAIL hold_rsvd: got %b/%0d/%b want %b/%0d/%b", pout, cnt, done, e.pout, e.cnt, e.done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shr_frame();
      test_rotate();
      test_back_to_back();
      test_enable();
      test_async_reset();
      test_asr_and_reserved();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
